// File: rtl/pix_mem_arbiter_if.sv
// pix_mem_if: request, grant, return and memory-port signals of the pixel memory arbiter
interface pix_mem_if #(
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 4,
    parameter int PIX_W  = 4
);
    logic              vid_req;
    logic              vid_gnt;
    logic              vid_bank;
    logic [ADDR_W-1:0] vid_addr;
    logic [SEL_W-1:0]  vid_sel;
    logic              vid_rvalid;
    logic [PIX_W-1:0]  vid_rdata;
    logic              host_req;
    logic              host_gnt;
    logic              host_we;
    logic              host_bank;
    logic [ADDR_W-1:0] host_addr;
    logic [SEL_W-1:0]  host_sel;
    logic [PIX_W-1:0]  host_wdata;
    logic              host_rvalid;
    logic [PIX_W-1:0]  host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic              mem_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_sel;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_pixel;

    modport master (
        output vid_req, vid_bank, vid_addr, vid_sel,
        output host_req, host_we, host_bank, host_addr, host_sel, host_wdata,
        output mem_pixel,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_bank, mem_addr, mem_sel, mem_wdata
    );

    modport slave (
        input  vid_req, vid_bank, vid_addr, vid_sel,
        input  host_req, host_we, host_bank, host_addr, host_sel, host_wdata,
        input  mem_pixel,
        output vid_gnt, vid_rvalid, vid_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_bank, mem_addr, mem_sel, mem_wdata
    );
endinterface

// File: rtl/pix_mem_arbiter.sv
// pix_mem_arbiter: video-over-host pixel memory arbiter with registered memory port and tagged read return; PIXARB_STARVE_GUARD_EN enables the host starvation guard
module pix_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int SEL_W      = 4,
    parameter int PIX_W      = 4,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input logic      clk,
    input logic      rst,
    pix_mem_if.slave bus
);
    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("pix_mem_arbiter: RD_LAT must be 0..3");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("pix_mem_arbiter: STARVE_MAX must be 1..15");
    end

    logic              starve_win;
    logic              vid_gnt;
    logic              host_gnt;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              mem_bank_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [SEL_W-1:0]  mem_sel_q;
    logic [PIX_W-1:0]  mem_wdata_q;
    logic [RD_LAT:0]   tag_v;
    logic [RD_LAT:0]   tag_h;
    logic              ret_vid;
    logic              ret_host;
    logic              vid_rvalid_q;
    logic              host_rvalid_q;
    logic [PIX_W-1:0]  vid_rdata_q;
    logic [PIX_W-1:0]  host_rdata_q;

`ifdef PIXARB_STARVE_GUARD_EN
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    // count cycles the host waits; at the limit the host overrides video once
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!bus.host_req || host_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign starve_win = starve_cnt == SMAX;
`else
    assign starve_win = 1'b0;
`endif

    // grants are combinational and forced low while reset is asserted
    assign host_gnt     = !rst && bus.host_req && (!bus.vid_req || starve_win);
    assign vid_gnt      = !rst && bus.vid_req && !host_gnt;
    assign bus.host_gnt = host_gnt;
    assign bus.vid_gnt  = vid_gnt;

    // memory port register: loads the winner's fields, holds them when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_bank_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= vid_gnt || host_gnt;
            mem_we_q <= host_gnt && bus.host_we;
            if (vid_gnt) begin
                mem_bank_q <= bus.vid_bank;
                mem_addr_q <= bus.vid_addr;
                mem_sel_q  <= bus.vid_sel;
            end else if (host_gnt) begin
                mem_bank_q  <= bus.host_bank;
                mem_addr_q  <= bus.host_addr;
                mem_sel_q   <= bus.host_sel;
                mem_wdata_q <= bus.host_wdata;
            end
        end
    end

    // tag pipeline: stage k describes the access issued k+1 cycles ago
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            tag_h <= '0;
        end else begin
            tag_v[0] <= vid_gnt || (host_gnt && !bus.host_we);
            tag_h[0] <= host_gnt;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_h[i] <= tag_h[i-1];
            end
        end
    end

    assign ret_vid  = tag_v[RD_LAT] && !tag_h[RD_LAT];
    assign ret_host = tag_v[RD_LAT] && tag_h[RD_LAT];

    // capture returning pixel for its owner; rdata holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            vid_rdata_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            vid_rvalid_q  <= ret_vid;
            host_rvalid_q <= ret_host;
            if (ret_vid)
                vid_rdata_q <= bus.mem_pixel;
            if (ret_host)
                host_rdata_q <= bus.mem_pixel;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_bank    = mem_bank_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.vid_rvalid  = vid_rvalid_q;
    assign bus.vid_rdata   = vid_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
endmodule

// File: tb/tb_pix_mem_arbiter.sv
// tb_pix_mem_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_pix_mem_arbiter;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 4;
`ifdef PIXARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        int         due;
        bit         host;
        logic [3:0] d;
    } ret_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] mem_store [0:8191];
    logic [3:0] ref_store [0:8191];

    pix_mem_if bus ();

    pix_mem_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // pixel memory with one cycle of read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem_store[{bus.mem_bank, bus.mem_addr, bus.mem_sel}] = bus.mem_wdata;
            else
                bus.mem_pixel <= mem_store[{bus.mem_bank, bus.mem_addr, bus.mem_sel}];
        end
    end

    task automatic clear_inputs();
        bus.vid_req = 0; bus.vid_bank = 0; bus.vid_addr = '0; bus.vid_sel = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_bank = 0; bus.host_addr = '0;
        bus.host_sel = '0; bus.host_wdata = '0;
    endtask

    task automatic test_reset();
        bus.vid_req = 1; bus.host_req = 1; bus.host_we = 1;
        @(negedge clk); #1;
        checks++; if (bus.vid_gnt !== 1'b0) begin failures++; $display("FAIL reset_vid_gnt got=%0h exp=0", bus.vid_gnt); end
        checks++; if (bus.host_gnt !== 1'b0) begin failures++; $display("FAIL reset_host_gnt got=%0h exp=0", bus.host_gnt); end
        checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0h exp=0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", bus.mem_we); end
        checks++; if ({bus.mem_bank, bus.mem_addr, bus.mem_sel, bus.mem_wdata} !== 17'd0) begin failures++; $display("FAIL reset_mem_fields got=%0h exp=0", {bus.mem_bank, bus.mem_addr, bus.mem_sel, bus.mem_wdata}); end
        checks++; if ({bus.vid_rvalid, bus.host_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%0b exp=00", {bus.vid_rvalid, bus.host_rvalid}); end
        checks++; if ({bus.vid_rdata, bus.host_rdata} !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", {bus.vid_rdata, bus.host_rdata}); end
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_video_read();
        mem_store[{1'b0, 8'h12, 4'h3}] = 4'hA;
        @(negedge clk);
        bus.vid_req = 1; bus.vid_bank = 0; bus.vid_addr = 8'h12; bus.vid_sel = 4'h3;
        #1;
        checks++; if (bus.vid_gnt !== 1'b1) begin failures++; $display("FAIL vrd_vid_gnt got=%0h exp=1", bus.vid_gnt); end
        checks++; if (bus.host_gnt !== 1'b0) begin failures++; $display("FAIL vrd_host_gnt got=%0h exp=0", bus.host_gnt); end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        checks++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin failures++; $display("FAIL vrd_mem_en_we got=%0b exp=10", {bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_sel} !== 12'h123) begin failures++; $display("FAIL vrd_mem_addr_sel got=%0h exp=123", {bus.mem_addr, bus.mem_sel}); end
        @(negedge clk); #1;
        checks++; if (bus.vid_rvalid !== 1'b0) begin failures++; $display("FAIL vrd_early_rvalid got=%0h exp=0", bus.vid_rvalid); end
        @(negedge clk); #1;
        checks++; if (bus.vid_rvalid !== 1'b1) begin failures++; $display("FAIL vrd_rvalid got=%0h exp=1", bus.vid_rvalid); end
        checks++; if (bus.vid_rdata !== 4'hA) begin failures++; $display("FAIL vrd_rdata got=%0h exp=a", bus.vid_rdata); end
        @(negedge clk); #1;
        checks++; if (bus.vid_rvalid !== 1'b0) begin failures++; $display("FAIL vrd_single_pulse got=%0h exp=0", bus.vid_rvalid); end
        checks++; if (bus.vid_rdata !== 4'hA) begin failures++; $display("FAIL vrd_rdata_hold got=%0h exp=a", bus.vid_rdata); end
        checks++; if ({bus.mem_en, bus.mem_addr} !== 9'h012) begin failures++; $display("FAIL vrd_idle_hold got=%0h exp=012", {bus.mem_en, bus.mem_addr}); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.vid_req = 1; bus.vid_addr = 8'h20; bus.vid_sel = 0;
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h30; bus.host_sel = 0; bus.host_wdata = 4'h7;
        #1;
        checks++; if ({bus.vid_gnt, bus.host_gnt} !== 2'b10) begin failures++; $display("FAIL prio_both got=%0b exp=10", {bus.vid_gnt, bus.host_gnt}); end
        @(negedge clk);
        bus.vid_req = 0;
        #1;
        checks++; if ({bus.vid_gnt, bus.host_gnt} !== 2'b01) begin failures++; $display("FAIL prio_host_next got=%0b exp=01", {bus.vid_gnt, bus.host_gnt}); end
        checks++; if (bus.mem_addr !== 8'h20) begin failures++; $display("FAIL prio_vid_addr got=%0h exp=20", bus.mem_addr); end
        @(negedge clk);
        bus.host_req = 0;
        #1;
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 13'h1307) begin failures++; $display("FAIL prio_host_write got=%0h exp=1307", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_starvation();
        bit eh;
        @(negedge clk);
        bus.vid_req = 1; bus.vid_addr = 8'h21;
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h50; bus.host_wdata = 4'h9;
        for (int k = 1; k <= 8; k++) begin
            #1;
            eh = GUARD && k == 5;
            checks++; if ({bus.vid_gnt, bus.host_gnt} !== {!eh, eh}) begin failures++; $display("FAIL starve_cycle%0d got=%0b exp=%0b", k, {bus.vid_gnt, bus.host_gnt}, {!eh, eh}); end
            @(negedge clk);
            if (eh) bus.host_req = 0;
        end
        clear_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_host_write();
        @(negedge clk);
        bus.host_req = 1; bus.host_we = 1; bus.host_bank = 1; bus.host_addr = 8'h40; bus.host_sel = 4'h2; bus.host_wdata = 4'h5;
        #1;
        checks++; if (bus.host_gnt !== 1'b1) begin failures++; $display("FAIL hwr_gnt got=%0h exp=1", bus.host_gnt); end
        @(negedge clk);
        bus.host_req = 0;
        #1;
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_bank} !== 3'b111) begin failures++; $display("FAIL hwr_ctrl got=%0b exp=111", {bus.mem_en, bus.mem_we, bus.mem_bank}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 12'h405) begin failures++; $display("FAIL hwr_addr_wdata got=%0h exp=405", {bus.mem_addr, bus.mem_wdata}); end
        @(negedge clk); #1;
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL hwr_we_drop got=%0h exp=0", bus.mem_we); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.host_rvalid !== 1'b0) begin failures++; $display("FAIL hwr_no_rvalid%0d got=%0h exp=0", k, bus.host_rvalid); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v [4];
        bit         ev;
        for (int i = 0; i < 4; i++) begin
            v[i] = 4'($urandom);
            mem_store[{1'b0, 8'(8'h60 + i), 4'h1}] = v[i];
        end
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            bus.vid_req = c < 4; bus.vid_bank = 0; bus.vid_addr = 8'(8'h60 + c); bus.vid_sel = 4'h1;
            #1;
            if (c < 4) begin
                checks++; if (bus.vid_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d got=%0h exp=1", c, bus.vid_gnt); end
            end
            ev = c >= 3 && c <= 6;
            checks++; if (bus.vid_rvalid !== ev) begin failures++; $display("FAIL b2b_rvalid%0d got=%0h exp=%0h", c, bus.vid_rvalid, ev); end
            if (ev) begin
                checks++; if (bus.vid_rdata !== v[c-3]) begin failures++; $display("FAIL b2b_rdata%0d got=%0h exp=%0h", c, bus.vid_rdata, v[c-3]); end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_reset_inflight();
        bus.vid_req = 1; bus.vid_bank = 0; bus.vid_addr = 8'h12; bus.vid_sel = 4'h3;
        #1;
        checks++; if (bus.vid_gnt !== 1'b1) begin failures++; $display("FAIL rstif_gnt got=%0h exp=1", bus.vid_gnt); end
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        checks++; if ({bus.vid_gnt, bus.host_gnt, bus.mem_en, bus.mem_we} !== 4'b0000) begin failures++; $display("FAIL rstif_ctrl got=%0b exp=0000", {bus.vid_gnt, bus.host_gnt, bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_bank, bus.mem_addr, bus.mem_sel, bus.mem_wdata} !== 17'd0) begin failures++; $display("FAIL rstif_mem_fields got=%0h exp=0", {bus.mem_bank, bus.mem_addr, bus.mem_sel, bus.mem_wdata}); end
        checks++; if ({bus.vid_rvalid, bus.host_rvalid, bus.vid_rdata, bus.host_rdata} !== 10'd0) begin failures++; $display("FAIL rstif_returns got=%0h exp=0", {bus.vid_rvalid, bus.host_rvalid, bus.vid_rdata, bus.host_rdata}); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (bus.vid_gnt !== 1'b1) begin failures++; $display("FAIL rstif_first_gnt got=%0h exp=1", bus.vid_gnt); end
        @(negedge clk);
        bus.vid_req = 0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if ({bus.vid_rvalid, bus.host_rvalid} !== {k == 3, 1'b0}) begin failures++; $display("FAIL rstif_rvalid%0d got=%0b exp=%0b", k, {bus.vid_rvalid, bus.host_rvalid}, {k == 3, 1'b0}); end
            if (k == 3) begin
                checks++; if (bus.vid_rdata !== 4'hA) begin failures++; $display("FAIL rstif_rdata got=%0h exp=a", bus.vid_rdata); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_traffic();
        ret_t       q [$];
        ret_t       r;
        int         starve = 0;
        bit         vp = 0, hp = 0, gv, gh, sw, ev, eh;
        logic       e_en = 0, e_we = 0, e_bank = 0;
        logic [7:0] e_addr = '0;
        logic [3:0] e_sel = '0, e_wdata = '0, lv = '0, lh = '0;
        logic [12:0] idx;
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8192; i++) ref_store[i] = mem_store[i];
        for (int c = 0; c < 406; c++) begin
            if (c >= 400) begin
                bus.vid_req = 0; bus.host_req = 0;
            end else begin
                if (!vp) begin
                    bus.vid_req = ($urandom % 3) != 0; bus.vid_bank = 1'($urandom);
                    bus.vid_addr = 8'($urandom % 16); bus.vid_sel = 4'($urandom % 4);
                end
                if (!hp) begin
                    bus.host_req = 1'($urandom); bus.host_we = 1'($urandom); bus.host_bank = 1'($urandom);
                    bus.host_addr = 8'($urandom % 16); bus.host_sel = 4'($urandom % 4); bus.host_wdata = 4'($urandom);
                end
            end
            #1;
            sw = GUARD && starve == STARVE_MAX;
            gh = bus.host_req && (!bus.vid_req || sw);
            gv = bus.vid_req && !gh;
            ev = 0; eh = 0;
            if (q.size() != 0 && q[0].due == c) begin
                r = q.pop_front();
                if (r.host) begin eh = 1; lh = r.d; end else begin ev = 1; lv = r.d; end
            end
            checks++; if ({bus.vid_gnt, bus.host_gnt} !== {gv, gh}) begin failures++; $display("FAIL rnd_gnt c=%0d got=%0b exp=%0b", c, {bus.vid_gnt, bus.host_gnt}, {gv, gh}); end
            checks++; if ({bus.mem_en, bus.mem_we} !== {e_en, e_we}) begin failures++; $display("FAIL rnd_mem_ctrl c=%0d got=%0b exp=%0b", c, {bus.mem_en, bus.mem_we}, {e_en, e_we}); end
            checks++; if ({bus.mem_bank, bus.mem_addr, bus.mem_sel} !== {e_bank, e_addr, e_sel}) begin failures++; $display("FAIL rnd_mem_fields c=%0d got=%0h exp=%0h", c, {bus.mem_bank, bus.mem_addr, bus.mem_sel}, {e_bank, e_addr, e_sel}); end
            if (e_we) begin
                checks++; if (bus.mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_mem_wdata c=%0d got=%0h exp=%0h", c, bus.mem_wdata, e_wdata); end
            end
            checks++; if ({bus.vid_rvalid, bus.host_rvalid} !== {ev, eh}) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%0b exp=%0b", c, {bus.vid_rvalid, bus.host_rvalid}, {ev, eh}); end
            checks++; if ({bus.vid_rdata, bus.host_rdata} !== {lv, lh}) begin failures++; $display("FAIL rnd_rdata c=%0d got=%0h exp=%0h", c, {bus.vid_rdata, bus.host_rdata}, {lv, lh}); end
            e_en = gv || gh;
            e_we = gh && bus.host_we;
            if (gv) begin
                e_bank = bus.vid_bank; e_addr = bus.vid_addr; e_sel = bus.vid_sel;
                q.push_back('{due: c + 2 + RD_LAT, host: 1'b0, d: ref_store[{bus.vid_bank, bus.vid_addr, bus.vid_sel}]});
            end else if (gh) begin
                e_bank = bus.host_bank; e_addr = bus.host_addr; e_sel = bus.host_sel; e_wdata = bus.host_wdata;
                idx = {bus.host_bank, bus.host_addr, bus.host_sel};
                if (bus.host_we) ref_store[idx] = bus.host_wdata;
                else q.push_back('{due: c + 2 + RD_LAT, host: 1'b1, d: ref_store[idx]});
            end
            starve = (bus.host_req && !gh) ? (starve < STARVE_MAX ? starve + 1 : starve) : 0;
            vp = bus.vid_req && !gv;
            hp = bus.host_req && !gh;
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost_returns got=%0d exp=0", q.size()); end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        for (int i = 0; i < 8192; i++) mem_store[i] = 4'($urandom);
        test_reset();
        test_video_read();
        test_priority();
        test_starvation();
        test_host_write();
        test_back_to_back();
        test_reset_inflight();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pix_mem_arbiter.md
PIX_MEM_ARBITER -- requirements
Module: pix_mem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, pixel memory address width.
REQ-002 SHALL provide parameter SEL_W, default 4, pixel-select width.
REQ-003 SHALL provide parameter PIX_W, default 4, pixel data width.
REQ-004 SHALL provide parameter RD_LAT, default 1, cycles from mem_* valid to mem_pixel valid (range 0..3).
REQ-005 SHALL provide parameter STARVE_MAX, default 4, host starvation limit in cycles (range 1..15).
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-007 vid_req  in  1, vid_gnt  out  1: video fetch request and same-cycle combinational grant.
REQ-008 vid_bank  in  1, vid_addr  in  ADDR_W, vid_sel  in  SEL_W: video read fields.
REQ-009 vid_rvalid  out  1, vid_rdata  out  PIX_W: video read return.
REQ-010 host_req  in  1, host_gnt  out  1, host_we  in  1: host request, grant, write flag.
REQ-011 host_bank  in  1, host_addr  in  ADDR_W, host_sel  in  SEL_W, host_wdata  in  PIX_W: host fields.
REQ-012 host_rvalid  out  1, host_rdata  out  PIX_W: host read return.
REQ-013 mem_en  out  1, mem_we  out  1, mem_bank  out  1, mem_addr  out  ADDR_W, mem_sel  out  SEL_W, mem_wdata  out  PIX_W: registered memory port.
REQ-014 mem_pixel  in  PIX_W: memory read data.

Function
REQ-015 At most one grant per cycle; a request with no grant SHALL hold its fields stable until granted.
REQ-016 Default priority: video over host; host granted only when vid_req low, or per REQ-021.
REQ-017 Granted request in cycle N SHALL drive mem_* during cycle N+1 with mem_en=1; mem_we=host_we for host, 0 for video.
REQ-018 Cycles without grant: mem_en=0, mem_we=0, other mem_* hold previous values.
REQ-019 Each granted read SHALL produce exactly one rvalid pulse to its originator in cycle N+2+RD_LAT, rdata = mem_pixel sampled at end of cycle N+1+RD_LAT; writes produce no rvalid.
REQ-020 Return routing SHALL use a RD_LAT+1-deep tag pipeline (valid, owner); back-to-back reads return in grant order, one per cycle, no loss.
REQ-021 Starvation counter (4-bit): increments each cycle host_req=1 and host_gnt=0, saturates at STARVE_MAX; when equal to STARVE_MAX host wins over video; clears on host_gnt or host_req=0.
REQ-022 rdata outputs hold last value when rvalid=0.

Reset
REQ-023 rst asserted SHALL immediately force vid_gnt, host_gnt (gated), mem_en, mem_we, both rvalid to 0, mem_bank/addr/sel/wdata and both rdata to 0, starvation counter and tag pipeline cleared.
REQ-024 Reads in flight at reset SHALL never produce rvalid after rst deasserts; first grant possible in first cycle after deassertion.

Configuration
REQ-025 Macro PIXARB_STARVE_GUARD_EN: defined -> REQ-021 active; undefined -> counter absent, strict video priority, host served only when vid_req=0.

Verification
REQ-026 Video read addr=0x12, sel=3, RD_LAT=1, mem returns 0xA -> vid_gnt same cycle, mem_en in N+1, vid_rvalid=1 with 0xA in N+3.
REQ-027 vid_req and host_req both high one cycle -> vid_gnt=1, host_gnt=0; host granted next cycle when vid_req drops.
REQ-028 Guard enabled, vid_req and host_req held high, STARVE_MAX=4 -> host_gnt on 5th cycle, vid_gnt=0 that cycle, then video resumes; guard disabled -> host never granted.
REQ-029 Host write addr=0x40, wdata=0x5 -> mem_we=1, mem_wdata=0x5 in N+1; no host_rvalid.
REQ-030 Four back-to-back video reads -> four consecutive vid_rvalid pulses, data in order.
REQ-031 rst asserted one cycle after a read grant -> all outputs 0 asynchronously, no rvalid after release.
